// File: rtl/fetcher_pkg.sv
// fetcher_pkg: shared constants and types for the instruction fetch controller.
//   ByteLength / PcLength / InstrLength : MSB indices of byte, pc and instruction
//   True / False                        : single-bit boolean constants
//   fc_state_t                          : fetch FSM encoding (FcIdle, FcRead, FcDone)
//   byte_addr()                         : 32-bit modulo byte address of base + offset
package fetcher_pkg;

  localparam int ByteLength  = 7;
  localparam int PcLength    = 31;
  localparam int InstrLength = 31;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef enum logic [1:0] {
    FcIdle = 2'd0,
    FcRead = 2'd1,
    FcDone = 2'd2
  } fc_state_t;

  // Wraps naturally at 2^32 because the result is PcLength+1 bits wide.
  function automatic logic [PcLength:0] byte_addr(input logic [PcLength:0] base,
                                                  input logic [2:0]        offset);
    return base + {29'd0, offset};
  endfunction

endpackage

// File: rtl/fetcher_icache.sv
// fetcher_icache: direct-mapped, one-word-per-line instruction cache.
//   clk, rst (async active-low, clears valid bits only)
//   lookup_pc -> hit, hit_data   : combinational lookup
//   wr_en, wr_pc, wr_data        : synchronous line fill
// Index = pc[log2(LINES)+1:2], tag = pc[31:log2(LINES)+2].
module fetcher_icache
  import fetcher_pkg::*;
#(
  parameter int LINES = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PcLength:0]    lookup_pc,
  output logic                 hit,
  output logic [InstrLength:0] hit_data,
  input  logic                 wr_en,
  input  logic [PcLength:0]    wr_pc,
  input  logic [InstrLength:0] wr_data
);

  localparam int IndexW = $clog2(LINES);
  localparam int TagW   = PcLength + 1 - IndexW - 2;

  logic [TagW-1:0]      tag_mem  [LINES];
  logic [InstrLength:0] data_mem [LINES];
  logic [LINES-1:0]     valid_reg;

  logic [IndexW-1:0] lookup_index;
  logic [TagW-1:0]   lookup_tag;
  logic [IndexW-1:0] wr_index;
  logic [TagW-1:0]   wr_tag;
  logic              unused_low;

  assign lookup_index = lookup_pc[IndexW+1:2];
  assign lookup_tag   = lookup_pc[PcLength:IndexW+2];
  assign wr_index     = wr_pc[IndexW+1:2];
  assign wr_tag       = wr_pc[PcLength:IndexW+2];
  // Word-aligned addresses: the byte-offset bits carry no information.
  assign unused_low   = ^{lookup_pc[1:0], wr_pc[1:0]};

  // Tag/data arrays have no reset; the valid vector alone gates hits.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '0;
    end else if (wr_en) begin
      valid_reg[wr_index] <= True;
    end
  end

  assign hit      = valid_reg[lookup_index] && (tag_mem[lookup_index] == lookup_tag);
  assign hit_data = data_mem[lookup_index];

endmodule

// File: rtl/fetcher.sv
// fetcher: instruction fetch controller between the instruction queue and the
// byte-wide shared RAM port. One request at a time; four sequential byte reads
// are assembled little-endian into a 32-bit word, returned with a one-cycle
// finish pulse. A ROB exception flushes any fetch in progress.
//   clk, rst (async active-low)
//   is_exception_from_rob, is_empty_from_iq, pc_from_iq  : request side inputs
//   is_stall_to_iq, is_finish_to_iq, instr_to_iq         : request side outputs
//   mem_busy, mem_din                                    : RAM port inputs
//   mem_a, mem_rd                                        : RAM port outputs
// Optional feature: define FETCHER_ICACHE_EN to add a direct-mapped cache of
// ICACHE_LINES one-word lines (fetcher_icache); hits finish the cycle after accept.
module fetcher
  import fetcher_pkg::*;
#(
  parameter int ICACHE_LINES = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 is_exception_from_rob,
  input  logic                 is_empty_from_iq,
  input  logic [PcLength:0]    pc_from_iq,
  output logic                 is_stall_to_iq,
  output logic                 is_finish_to_iq,
  output logic [InstrLength:0] instr_to_iq,
  input  logic                 mem_busy,
  input  logic [ByteLength:0]  mem_din,
  output logic [PcLength:0]    mem_a,
  output logic                 mem_rd
);

  fc_state_t            state_reg, state_next;
  logic [PcLength:0]    pc_reg;
  logic [2:0]           icnt_reg;      // bytes issued, 0..4
  logic [2:0]           rcnt_reg;      // bytes received, 0..4
  logic                 inflight_reg;  // a read was issued last cycle
  logic [InstrLength:0] asm_reg;       // partial word being assembled
  logic [InstrLength:0] instr_out_reg; // last completed word

  logic                 accept;
  logic                 capture;
  logic                 last_capture;
  logic                 cache_hit;
  logic [InstrLength:0] cache_data;

  assign accept       = (state_reg == FcIdle) && !is_empty_from_iq && !is_exception_from_rob;
  assign capture      = (state_reg == FcRead) && inflight_reg;
  assign last_capture = capture && (rcnt_reg == 3'd3);

`ifdef FETCHER_ICACHE_EN
  fetcher_icache #(
    .LINES(ICACHE_LINES)
  ) u_icache (
    .clk      (clk),
    .rst      (rst),
    .lookup_pc(pc_from_iq),
    .hit      (cache_hit),
    .hit_data (cache_data),
    .wr_en    (state_reg == FcDone),
    .wr_pc    (pc_reg),
    .wr_data  (instr_out_reg)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (ICACHE_LINES > 0);
  assign cache_hit  = False;
  assign cache_data = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= FcIdle;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (is_exception_from_rob) begin
      state_next = FcIdle;
    end else begin
      case (state_reg)
        FcIdle:  if (accept) state_next = cache_hit ? FcDone : FcRead;
        FcRead:  if (last_capture) state_next = FcDone;
        FcDone:  state_next = FcIdle;
        default: state_next = FcIdle;
      endcase
    end
  end

  // Outputs
  always_comb begin
    mem_rd          = (state_reg == FcRead) && (icnt_reg < 3'd4) && !mem_busy;
    mem_a           = byte_addr(pc_reg, icnt_reg);
    is_stall_to_iq  = (state_reg != FcIdle) || is_exception_from_rob;
    is_finish_to_iq = (state_reg == FcDone);
    instr_to_iq     = instr_out_reg;
  end

  // Datapath: counters, byte assembly and the held output word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg        <= '0;
      icnt_reg      <= '0;
      rcnt_reg      <= '0;
      inflight_reg  <= False;
      asm_reg       <= '0;
      instr_out_reg <= '0;
    end else begin
      // An exception drops the byte in flight so a stale response is never captured.
      inflight_reg <= is_exception_from_rob ? False : mem_rd;
      if (is_exception_from_rob) begin
        icnt_reg <= '0;
        rcnt_reg <= '0;
      end else if (accept) begin
        pc_reg   <= pc_from_iq;
        icnt_reg <= '0;
        rcnt_reg <= '0;
        if (cache_hit) instr_out_reg <= cache_data;
      end else begin
        if (mem_rd) icnt_reg <= icnt_reg + 3'd1;
        if (capture) begin
          asm_reg[{rcnt_reg[1:0], 3'b000} +: 8] <= mem_din;
          rcnt_reg <= rcnt_reg + 3'd1;
        end
        // The fourth byte goes straight into the output word this same edge.
        if (last_capture) instr_out_reg <= {mem_din, asm_reg[23:0]};
      end
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// tb_fetcher: self-checking bench for fetcher. A transaction-level reference
// model (address queue, finish deadline, last-word register, optional cache map)
// predicts every output each cycle; a table of cycle vectors and several
// hand-written sequences cover the directed scenarios, then random traffic runs.
module tb_fetcher;

  localparam int LINES = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc, empty, busy;
  logic [31:0] pc;
  logic        stall, fin, mem_rd;
  logic [31:0] instr, mem_a;
  logic [7:0]  mem_din;

  always #5 clk = ~clk;

  fetcher #(.ICACHE_LINES(LINES)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .is_exception_from_rob(exc),
    .is_empty_from_iq     (empty),
    .pc_from_iq           (pc),
    .is_stall_to_iq       (stall),
    .is_finish_to_iq      (fin),
    .instr_to_iq          (instr),
    .mem_busy             (busy),
    .mem_din              (mem_din),
    .mem_a                (mem_a),
    .mem_rd               (mem_rd)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // RAM contents: a few fixed bytes, hashed values elsewhere.
  logic [7:0] ram [bit [31:0]];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    if (ram.exists(a)) return ram[a];
    h = a * 32'h9E3779B1;
    return h[31:24];
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  // Reference model state
  bit          m_busy;
  logic [31:0] m_q[$];
  int          m_fin_at;
  logic [31:0] m_word, m_last, m_pc;
  int          acc_cyc, fin_cyc;
`ifdef FETCHER_ICACHE_EN
  bit          m_cv  [LINES];
  logic [31:0] m_cpc [LINES];
`endif

  logic        o_stall, o_rd, o_fin;
  logic [31:0] o_a, o_instr;
  logic        s_rd = 1'b0;
  logic [31:0] s_a  = '0;

  task automatic model_reset();
    m_busy   = 1'b0;
    m_q.delete();
    m_fin_at = -1;
    m_last   = '0;
`ifdef FETCHER_ICACHE_EN
    for (int i = 0; i < LINES; i++) m_cv[i] = 1'b0;
`endif
  endtask

  task automatic model_step(input logic e, input logic x, input logic b, input logic [31:0] p);
    logic exp_stall, exp_rd, exp_fin, acc;
    int   idx;
    exp_stall = m_busy || x;
    exp_rd    = m_busy && (m_q.size() > 0) && !b;
    chk("stall", o_stall, exp_stall);
    chk("mem_rd", o_rd, exp_rd);
    if (exp_rd) begin
      chk("mem_a", o_a, m_q[0]);
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_fin_at = cyc + 2;
    end
    exp_fin = m_busy && (m_fin_at == cyc);
    chk("finish", o_fin, exp_fin);
    if (exp_fin) begin
      m_last = m_word;
      m_busy = 1'b0;
`ifdef FETCHER_ICACHE_EN
      idx = int'((m_pc >> 2) % LINES);
      m_cv[idx]  = 1'b1;
      m_cpc[idx] = m_pc;
`endif
    end
    chk("instr", o_instr, m_last);
    acc = !exp_stall && !e;
    if (x) begin
      m_busy   = 1'b0;
      m_q.delete();
      m_fin_at = -1;
    end else if (acc) begin
      m_busy   = 1'b1;
      m_pc     = p;
      m_word   = word_at(p);
      m_fin_at = -1;
      acc_cyc  = cyc;
      idx      = int'((p >> 2) % LINES);
`ifdef FETCHER_ICACHE_EN
      if (m_cv[idx] && m_cpc[idx] == p) m_fin_at = cyc + 1;
      else for (int i = 0; i < 4; i++) m_q.push_back(p + 32'(i));
`else
      for (int i = 0; i < 4; i++) m_q.push_back(p + 32'(i) + 32'(idx * 0));
`endif
    end
    if (o_fin) fin_cyc = cyc;
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, check, present RAM data.
  task automatic cycle(input logic e, input logic x, input logic b, input logic [31:0] p);
    empty = e; exc = x; busy = b; pc = p;
    @(negedge clk);
    o_stall = stall; o_rd = mem_rd; o_a = mem_a; o_fin = fin; o_instr = instr;
    model_step(e, x, b, p);
    s_rd = mem_rd;
    s_a  = mem_a;
    @(posedge clk);
    #1;
    mem_din = s_rd ? mem_byte(s_a) : 8'($urandom);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    chk({tag, "_mem_a"}, mem_a, 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_finish"}, 32'(fin), 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
  endtask

  typedef struct {
    logic        e;
    logic [31:0] p;
    logic        x_stall;
    logic        x_rd;
    logic        chk_a;
    logic [31:0] x_a;
    logic        x_fin;
    logic [31:0] x_instr;
  } vec_t;

  // Plain fetch of 0x1000 straight after reset; row i is cycle T+i.
  task automatic run_table();
    vec_t tbl[8];
    tbl[0] = '{1'b0, 32'h1000, 1'b0, 1'b0, 1'b1, 32'h0,    1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h0,    1'b1, 1'b1, 1'b1, 32'h1000, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 32'h0,    1'b1, 1'b1, 1'b1, 32'h1001, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 32'h0,    1'b1, 1'b1, 1'b1, 32'h1002, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 32'h0,    1'b1, 1'b1, 1'b1, 32'h1003, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 32'h0};
    tbl[6] = '{1'b1, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 32'h00000513};
    tbl[7] = '{1'b1, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 32'h00000513};
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].e, 1'b0, 1'b0, tbl[i].p);
      chk($sformatf("tbl%0d_stall", i), 32'(o_stall), 32'(tbl[i].x_stall));
      chk($sformatf("tbl%0d_mem_rd", i), 32'(o_rd), 32'(tbl[i].x_rd));
      if (tbl[i].chk_a) chk($sformatf("tbl%0d_mem_a", i), o_a, tbl[i].x_a);
      chk($sformatf("tbl%0d_finish", i), 32'(o_fin), 32'(tbl[i].x_fin));
      chk($sformatf("tbl%0d_instr", i), o_instr, tbl[i].x_instr);
    end
  endtask

  initial begin
    int t0;
    logic [31:0] rpc;
    rst = 1'b0; empty = 1'b1; exc = 1'b0; busy = 1'b0; pc = '0; mem_din = '0;
    ram[32'h1000] = 8'h13;
    ram[32'h1001] = 8'h05;
    ram[32'h1002] = 8'h00;
    ram[32'h1003] = 8'h00;
    model_reset();
    #12;
    chk_reset_outputs("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Plain fetch, table driven
    run_table();
    idle(2);

    // mem_busy at T+2 and T+3
    fin_cyc = -1;
    cycle(1'b0, 1'b0, 1'b0, 32'h1000);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h0);
    idle(8);
    chk("busy_latency", 32'(fin_cyc - acc_cyc), 32'd8);
    chk("busy_word", instr, 32'h00000513);

    // Exception mid-READ, then a fresh request at T+4
    fin_cyc = -1;
    cycle(1'b0, 1'b0, 1'b0, 32'h1000);
    idle(2);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h2000);
    t0 = acc_cyc;
    idle(8);
    chk("exc_new_latency", 32'(fin_cyc - t0), 32'd6);
    chk("exc_new_word", instr, word_at(32'h2000));

    // Back-to-back 0x1000, 0x1004
    t0 = cyc;
    cycle(1'b0, 1'b0, 1'b0, 32'h1000);
    idle(6);
    cycle(1'b0, 1'b0, 1'b0, 32'h1004);
    chk("b2b_accept", 32'(acc_cyc - t0), 32'd7);
    idle(8);
    chk("b2b_word", instr, word_at(32'h1004));

    // Address wrap at the top of memory
    cycle(1'b0, 1'b0, 1'b0, 32'hFFFFFFFC);
    idle(8);
    chk("wrap_word", instr, word_at(32'hFFFFFFFC));

`ifdef FETCHER_ICACHE_EN
    cycle(1'b0, 1'b0, 1'b0, 32'h1000);
    idle(8);
    fin_cyc = -1;
    t0 = cyc;
    cycle(1'b0, 1'b0, 1'b0, 32'h1000);
    idle(3);
    chk("hit_latency", 32'(fin_cyc - t0), 32'd1);
    chk("hit_word", instr, 32'h00000513);
    fin_cyc = -1;
    t0 = cyc;
    cycle(1'b0, 1'b0, 1'b0, 32'h1000 + 32'(4 * LINES));
    idle(8);
    chk("alias_miss_latency", 32'(fin_cyc - t0), 32'd6);
`endif

    // Asynchronous reset in the middle of READ
    cycle(1'b0, 1'b0, 1'b0, 32'h1000);
    idle(2);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    mem_din = '0;
    run_table();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 16 == 0) rpc = 32'hFFFFFFFC;
      else rpc = 32'h1000 + 32'(($urandom % 48) * 4) + (($urandom % 2) ? 32'(4 * LINES) : 32'd0);
      cycle(1'($urandom % 2), 1'($urandom % 40 == 0), 1'($urandom % 4 == 0), rpc);
    end
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
